// File: rtl/ugame_pkg.sv
// -----------------------------------------------------------------------------
// ugame_pkg
//   Shared definitions for the rhythm-game note datapath.
//   - state_t   : controller state encoding (3 bits, ST_IDLE..ST_DONE)
//   - SCORE_MAX : score saturation ceiling, the largest value score_display shows
//   - UGAME_LANE: slice helper that selects lane <idx> of a packed lane bus
// -----------------------------------------------------------------------------
`ifndef UGAME_LANE
`define UGAME_LANE(vec, idx, len) vec[(idx)*(len) +: (len)]
`endif

package ugame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_SHIFT = 3'd3,
      ST_JUDGE = 3'd4,
      ST_PAUSE = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   localparam int SCORE_MAX = 20;

endpackage

// File: rtl/press_edge_latch.sv
// -----------------------------------------------------------------------------
// press_edge_latch
//   Captures one rising edge of a key per judge window.
//   Ports:
//     clk     in  system clock
//     resetn  in  asynchronous active-low reset
//     en      in  edge capture enabled (play states: RUN, SHIFT, JUDGE)
//     clr     in  clear the latch (window boundary or song load)
//     press   in  synchronised key level
//     latched out 1 = an edge was seen in the current window
//   The previous-level register tracks the key in every state, so a key held
//   across a pause never looks like a fresh edge when play resumes.
// -----------------------------------------------------------------------------
module press_edge_latch (
   input  logic clk,
   input  logic resetn,
   input  logic en,
   input  logic clr,
   input  logic press,
   output logic latched
);

   logic prev_q;
   logic latched_q, latched_d;
   logic edge_seen;

   assign edge_seen = press & ~prev_q;

   // Clear wins over the old contents, but an edge landing in the clearing
   // cycle itself is kept so it scores in the following window.
   always_comb begin
      latched_d = latched_q;
      if (clr) begin
         latched_d = en & edge_seen;
      end else if (en && edge_seen) begin
         latched_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         prev_q    <= 1'b0;
         latched_q <= 1'b0;
      end else begin
         prev_q    <= press;
         latched_q <= latched_d;
      end
   end

   assign latched = latched_q;

endmodule

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
//   Game controller: loads lane patterns, shifts lanes on each rate tick,
//   judges key presses against the target slot (bit 0 of every lane), keeps a
//   saturating score and sequences start / pause / end-of-song.
//   Ports:
//     clk, resetn     clock, asynchronous active-low reset
//     running         level, 1 = play, 0 = pause / stop
//     tick            1-cycle lane-step pulse from the rate divider
//     press           per-lane key levels (synchronised)
//     pattern_in      song pattern, lane i = [i*LANE_LEN +: LANE_LEN]
//     lanes_out       live lane contents for drawing
//     score           current score, clamped to 0..SCORE_MAX
//     hit, miss       per-lane judge flags, only valid in the JUDGE cycle
//     tick_overrun    sticky: a tick came while busy (LOAD/SHIFT/JUDGE/DONE)
//     done            song finished, score frozen
//   Timing: tick sampled in RUN -> lanes shifted one clock later, hit/miss
//   visible in the JUDGE cycle, score updated at the end of JUDGE.
// -----------------------------------------------------------------------------
module note_sequencer #(
   parameter int NUM_LANES = 4,
   parameter int LANE_LEN  = 26,
   parameter int SCORE_W   = 5,
   parameter int SCORE_MAX = ugame_pkg::SCORE_MAX
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          running,
   input  logic                          tick,
   input  logic [NUM_LANES-1:0]          press,
   input  logic [NUM_LANES*LANE_LEN-1:0] pattern_in,
   output logic [NUM_LANES*LANE_LEN-1:0] lanes_out,
   output logic [SCORE_W-1:0]            score,
   output logic [NUM_LANES-1:0]          hit,
   output logic [NUM_LANES-1:0]          miss,
   output logic                          tick_overrun,
   output logic                          done
);

   import ugame_pkg::*;

   // Two spare bits: one for the sign, one so score + NUM_LANES cannot wrap.
   localparam int ACC_W = SCORE_W + 2;
   localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(SCORE_MAX);
   localparam logic signed [ACC_W-1:0] ONE_S = ACC_W'(1);

   state_t                          state_q, state_d;
   logic [NUM_LANES*LANE_LEN-1:0]   lanes_q, lanes_d;
   logic [NUM_LANES*LANE_LEN-1:0]   lanes_shift;
   logic [NUM_LANES-1:0]            tgt_q, tgt_d;
   logic [NUM_LANES-1:0]            tgt_now;
   logic [SCORE_W-1:0]              score_q, score_d;
   logic                            overrun_q, overrun_d;

   logic [NUM_LANES-1:0]            latched;
   logic                            latch_en, latch_clr;
   logic [NUM_LANES-1:0]            hit_v, miss_v;
   logic signed [ACC_W-1:0]         sum, acc;
   logic                            judge_active;

   // Per-lane shift path and key latch.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         assign `UGAME_LANE(lanes_shift, gi, LANE_LEN) =
                `UGAME_LANE(lanes_q, gi, LANE_LEN) >> 1;
         assign tgt_now[gi] = lanes_q[gi*LANE_LEN];

         press_edge_latch u_latch (
            .clk     (clk),
            .resetn  (resetn),
            .en      (latch_en),
            .clr     (latch_clr),
            .press   (press[gi]),
            .latched (latched[gi])
         );
      end
   endgenerate

   // Judge: a hit needs both note and press; any other mismatch is a miss
   // (missed note or stray press).
   assign judge_active = (state_q == ST_JUDGE);
   assign hit_v        = tgt_q & latched;
   assign miss_v       = tgt_q ^ latched;

   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (hit_v[i]) begin
            sum = sum + ONE_S;
         end else if (miss_v[i]) begin
            sum = sum - ONE_S;
         end
      end
      acc = $signed({2'b00, score_q}) + sum;
   end

   // Next-state and datapath control.
   always_comb begin
      state_d   = state_q;
      lanes_d   = lanes_q;
      tgt_d     = tgt_q;
      score_d   = score_q;
      overrun_d = overrun_q;
      latch_en  = 1'b0;
      latch_clr = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (running) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            lanes_d   = pattern_in;
            score_d   = '0;
            latch_clr = 1'b1;
            overrun_d = tick;      // a tick in this very cycle still counts
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            latch_en = 1'b1;
            if (!running) begin
               state_d = ST_PAUSE;
            end else if (tick) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            latch_en = 1'b1;
            lanes_d  = lanes_shift;
            tgt_d    = tgt_now;
            if (tick) overrun_d = 1'b1;
            state_d  = ST_JUDGE;
         end
         ST_JUDGE: begin
            latch_en  = 1'b1;
            latch_clr = 1'b1;
            if (acc < 0) begin
               score_d = '0;
            end else if (acc > MAX_S) begin
               score_d = SCORE_W'(SCORE_MAX);
            end else begin
               score_d = acc[SCORE_W-1:0];
            end
            if (tick) overrun_d = 1'b1;
            // lanes_q already holds the post-shift contents here.
            state_d = (lanes_q == '0) ? ST_DONE : ST_RUN;
         end
         ST_PAUSE: begin
            if (running) state_d = ST_RUN;
         end
         ST_DONE: begin
            if (tick) overrun_d = 1'b1;
            if (!running) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         lanes_q   <= '0;
         tgt_q     <= '0;
         score_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lanes_q   <= lanes_d;
         tgt_q     <= tgt_d;
         score_q   <= score_d;
         overrun_q <= overrun_d;
      end
   end

   assign lanes_out    = lanes_q;
   assign score        = score_q;
   assign hit          = judge_active ? hit_v  : '0;
   assign miss         = judge_active ? miss_v : '0;
   assign tick_overrun = overrun_q;
   assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
//   Directed bench: a table of single-window judge vectors plus hand-written
//   sequences for saturation, clamping, JUDGE-cycle edges, pause and reset.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_note_sequencer;

   logic         clk = 1'b0;
   logic         resetn;
   logic         running;
   logic         tick;
   logic [3:0]   press;
   logic [103:0] pattern_in;
   logic [103:0] lanes_out;
   logic [4:0]   score;
   logic [3:0]   hit;
   logic [3:0]   miss;
   logic         tick_overrun;
   logic         done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0]   w_hit, w_miss, w_after;
   logic [103:0] w_lanes;
   logic [4:0]   w_score;
   logic [3:0]   flag_acc;

   typedef struct {
      logic [3:0] tgt;
      logic [3:0] prs;
      logic [3:0] exp_hit;
      logic [3:0] exp_miss;
      logic [4:0] exp_score;
   } vec_t;

   vec_t vecs[8];

   note_sequencer dut (
      .clk          (clk),
      .resetn       (resetn),
      .running      (running),
      .tick         (tick),
      .press        (press),
      .pattern_in   (pattern_in),
      .lanes_out    (lanes_out),
      .score        (score),
      .hit          (hit),
      .miss         (miss),
      .tick_overrun (tick_overrun),
      .done         (done)
   );

   always #5 clk = ~clk;

   function automatic logic [103:0] mk(input logic [25:0] l0, input logic [25:0] l1,
                                       input logic [25:0] l2, input logic [25:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reset, load a pattern and leave the DUT in RUN at a falling edge.
   task automatic start_song(input logic [103:0] pat);
      @(negedge clk);
      resetn = 1'b0; running = 1'b0; tick = 1'b0; press = 4'b0; pattern_in = pat;
      @(negedge clk);
      resetn = 1'b1; running = 1'b1;
      @(negedge clk);   // IDLE -> LOAD
      @(negedge clk);   // LOAD -> RUN
   endtask

   // One judge window: key edge, tick, sample in JUDGE, sample score after.
   task automatic window(input logic [3:0] prs, input logic rel);
      press = prs;
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      w_hit = hit; w_miss = miss; w_lanes = lanes_out;
      if (rel) press = 4'b0;
      @(negedge clk);
      w_score = score; w_after = hit | miss;
      $display("window press=%b hit=%b miss=%b score=%0d done=%b", prs, w_hit, w_miss, w_score, done);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "timeout");
   end

   initial begin
      //             tgt      prs      hit      miss     score
      vecs[0] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 5'd1};
      vecs[1] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 5'd0};
      vecs[2] = '{4'b1111, 4'b1111, 4'b1111, 4'b0000, 5'd4};
      vecs[3] = '{4'b1111, 4'b0101, 4'b0101, 4'b1010, 5'd0};
      vecs[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 5'd0};
      vecs[5] = '{4'b1100, 4'b1110, 4'b1100, 4'b0010, 5'd1};
      vecs[6] = '{4'b0110, 4'b1001, 4'b0000, 4'b1111, 5'd0};
      vecs[7] = '{4'b1011, 4'b0011, 4'b0011, 4'b1000, 5'd1};

      resetn = 1'b0; running = 1'b0; tick = 1'b0; press = 4'b0; pattern_in = '0;
      @(negedge clk);
      chk("reset_lanes", lanes_out, 0);
      chk("reset_score", score, 0);
      chk("reset_flags", {hit, miss}, 0);
      chk("reset_overrun", tick_overrun, 0);
      chk("reset_done", done, 0);
      resetn = 1'b1;

      // Two notes on lane 0, both hit.
      start_song(mk(26'h3, 26'h0, 26'h0, 26'h0));
      window(4'b0001, 1'b1);
      chk("t1_hit1", w_hit, 4'b0001);
      chk("t1_miss1", w_miss, 4'b0000);
      chk("t1_lanes1", w_lanes, mk(26'h1, 26'h0, 26'h0, 26'h0));
      chk("t1_score1", w_score, 1);
      chk("t1_notdone", done, 0);
      window(4'b0001, 1'b1);
      chk("t1_hit2", w_hit, 4'b0001);
      chk("t1_score2", w_score, 2);
      chk("t1_done", done, 1);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      chk("t1_done_overrun", tick_overrun, 1);
      chk("t1_done_frozen", score, 2);
      running = 1'b0;
      @(negedge clk);
      chk("t1_idle_done", done, 0);
      chk("t1_idle_score", score, 2);
      // Restart from IDLE with an all-zero song: LOAD clears, first JUDGE ends it.
      pattern_in = '0; running = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("zero_load_score", score, 0);
      chk("zero_load_overrun", tick_overrun, 0);
      window(4'b0000, 1'b1);
      chk("zero_flags", {w_hit, w_miss}, 0);
      chk("zero_done", done, 1);

      // Table of single-window judgements from score 0.
      for (int v = 0; v < 8; v++) begin
         start_song(mk({25'h0, vecs[v].tgt[0]}, {25'h0, vecs[v].tgt[1]},
                       {25'h0, vecs[v].tgt[2]}, {20'h0, 1'b1, 4'h0, vecs[v].tgt[3]}));
         window(vecs[v].prs, 1'b1);
         chk($sformatf("vec%0d_hit", v), w_hit, vecs[v].exp_hit);
         chk($sformatf("vec%0d_miss", v), w_miss, vecs[v].exp_miss);
         chk($sformatf("vec%0d_score", v), w_score, vecs[v].exp_score);
         chk($sformatf("vec%0d_lanes", v), w_lanes, mk(26'h0, 26'h0, 26'h0, 26'h10));
         chk($sformatf("vec%0d_flags_after", v), w_after, 4'b0000);
      end

      // Saturation at 20.
      start_song(mk(26'h3FFFFF, 26'h0, 26'h0, 26'h0));
      for (int k = 0; k < 20; k++) window(4'b0001, 1'b1);
      chk("sat_score20", w_score, 20);
      window(4'b0001, 1'b1);
      chk("sat_hit", w_hit, 4'b0001);
      chk("sat_hold20", w_score, 20);

      // Score 3, then four stray presses: clamp at 0.
      start_song(mk(26'h7, 26'h400, 26'h0, 26'h0));
      for (int k = 0; k < 3; k++) window(4'b0001, 1'b1);
      chk("clamp_score3", w_score, 3);
      window(4'b1111, 1'b1);
      chk("clamp_miss", w_miss, 4'b1111);
      chk("clamp_hit", w_hit, 4'b0000);
      chk("clamp_floor", w_score, 0);

      // Key edge in the JUDGE cycle counts toward the next window.
      start_song(mk(26'h0, 26'h0, 26'h3, 26'h100000));
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      chk("jedge_miss1", miss, 4'b0100);
      press = 4'b0100;
      @(negedge clk);
      chk("jedge_score1", score, 0);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      chk("jedge_hit2", hit, 4'b0100);
      chk("jedge_miss2", miss, 4'b0000);
      press = 4'b0;
      @(negedge clk);
      chk("jedge_score2", score, 1);

      // Pause: ticks and presses ignored, held key gives no edge on resume.
      start_song(mk(26'hF, 26'h8000, 26'h0, 26'h0));
      window(4'b0001, 1'b1);
      running = 1'b0;
      @(negedge clk);
      flag_acc = 4'b0;
      for (int k = 0; k < 5; k++) begin
         press = k[0] ? 4'b1111 : 4'b0000;
         tick = 1'b1;
         @(negedge clk);
         flag_acc = flag_acc | hit | miss;
         tick = 1'b0;
         @(negedge clk);
         flag_acc = flag_acc | hit | miss;
      end
      press = 4'b0001;
      @(negedge clk);
      chk("pause_lanes", lanes_out, mk(26'h7, 26'h4000, 26'h0, 26'h0));
      chk("pause_flags", flag_acc, 4'b0000);
      chk("pause_overrun", tick_overrun, 0);
      running = 1'b1;
      @(negedge clk);
      window(4'b0001, 1'b1);
      chk("resume_hit", w_hit, 4'b0000);
      chk("resume_miss", w_miss, 4'b0001);
      chk("resume_score", w_score, 0);

      // Ticks two cycles apart, then asynchronous reset during SHIFT.
      start_song(mk(26'hF, 26'h0, 26'h0, 26'h0));
      window(4'b0001, 1'b1);
      press = 4'b0001;
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      chk("ovr_hit", hit, 4'b0001);
      tick = 1'b1;
      press = 4'b0;
      @(negedge clk);
      tick = 1'b0;
      chk("ovr_flag", tick_overrun, 1);
      chk("ovr_score", score, 2);
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      chk("pre_rst_lanes", lanes_out, mk(26'h3, 26'h0, 26'h0, 26'h0));
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_lanes", lanes_out, 0);
      chk("arst_score", score, 0);
      chk("arst_overrun", tick_overrun, 0);
      chk("arst_flags_done", {hit, miss, done}, 0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
